// File: rtl/tsc_pkg.sv
// Shared constants for the alarm-clock time setter: FSM state codes, display
// mode codes, BCD limits, button bit positions and default timing parameters.
package tsc_pkg;

    // FSM state encoding (kept as plain constants for legacy tooling)
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_EDIT_TIME  = 3'd1;
    localparam logic [2:0] ST_EDIT_ALARM = 3'd2;
    localparam logic [2:0] ST_COMMIT_T   = 3'd3;
    localparam logic [2:0] ST_COMMIT_A   = 3'd4;

    // Display hint codes driven on the mode output
    localparam logic [1:0] MODE_IDLE       = 2'd0;
    localparam logic [1:0] MODE_EDIT_TIME  = 2'd1;
    localparam logic [1:0] MODE_EDIT_ALARM = 2'd2;

    // Largest legal value of each edited field
    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;

    // Bit positions inside the packed button vector
    localparam int B_MODE = 5;
    localparam int B_HOUR = 4;
    localparam int B_MIN  = 3;
    localparam int B_SET  = 2;
    localparam int B_AL   = 1;
    localparam int B_STOP = 0;

    // Default timing, all counted in clk_1s cycles
    localparam int HOLD_SECS_DEF     = 2;
    localparam int TIMEOUT_SECS_DEF  = 10;
    localparam int RING_MAX_SECS_DEF = 60;

    // Display mode for a given state; a commit cycle still shows the field being committed
    function automatic logic [1:0] mode_code(input logic [2:0] st);
        logic [1:0] code;
        case (st)
            ST_EDIT_TIME,  ST_COMMIT_T: code = MODE_EDIT_TIME;
            ST_EDIT_ALARM, ST_COMMIT_A: code = MODE_EDIT_ALARM;
            default:                    code = MODE_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Bundle between the button/clock side (master) and the time setter (slave):
// debounced buttons, the clock's current time and alarm, and the load-side outputs.
interface time_set_ctrl_if;

    logic       btn_mode;
    logic       btn_hour;
    logic       btn_min;
    logic       btn_set;
    logic       btn_al;
    logic       btn_stop;
    logic       alarm;
    logic [1:0] cur_h1;
    logic [3:0] cur_h0;
    logic [3:0] cur_m1;
    logic [3:0] cur_m0;

    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       AL_ON;
    logic       STOP_al;
    logic [1:0] mode;

    modport master (
        output btn_mode, btn_hour, btn_min, btn_set, btn_al, btn_stop,
        output alarm, cur_h1, cur_h0, cur_m1, cur_m0,
        input  H_in1, H_in0, M_in1, M_in0,
        input  LD_time, LD_alarm, AL_ON, STOP_al, mode
    );

    modport slave (
        input  btn_mode, btn_hour, btn_min, btn_set, btn_al, btn_stop,
        input  alarm, cur_h1, cur_h0, cur_m1, cur_m0,
        output H_in1, H_in0, M_in1, M_in0,
        output LD_time, LD_alarm, AL_ON, STOP_al, mode
    );

endinterface

// File: rtl/time_set_ctrl_bcd_inc.sv
// Registered two-digit BCD field with load and wrap-around increment.
// TW is the width of the tens digit; MAX is the largest legal value (e.g. 23 or 59).
// Load has priority over increment; the field wraps from MAX back to zero.
module bcd_inc #(
    parameter int TW  = 2,
    parameter int MAX = 23
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW+3:0] load_val,
    input  logic          inc,
    output logic [TW+3:0] value
);

    localparam logic [TW-1:0] MAX_TENS = TW'(MAX / 10);
    localparam logic [3:0]    MAX_ONES = 4'(MAX % 10);

    logic [TW-1:0] tens_s;
    logic [3:0]    ones_s;

    assign tens_s = value[TW+3:4];
    assign ones_s = value[3:0];

    // Field register: load, or step to the next legal BCD value with wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= {(TW+4){1'b0}};
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            if ((tens_s == MAX_TENS) && (ones_s == MAX_ONES)) begin
                value <= {(TW+4){1'b0}};
            end else if (ones_s == 4'd9) begin
                value <= {tens_s + TW'(1), 4'd0};
            end else begin
                value <= {tens_s, ones_s + 4'd1};
            end
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Alarm clock time setter. Turns debounced buttons into edited BCD hour/minute
// values plus one-cycle load strobes, the alarm-enable level and stop pulses.
// Everything runs on the 1 Hz tick clock shared with the alarm clock.
module time_set_ctrl
    import tsc_pkg::*;
#(
    parameter int HOLD_SECS     = HOLD_SECS_DEF,
    parameter int TIMEOUT_SECS  = TIMEOUT_SECS_DEF,
    parameter int RING_MAX_SECS = RING_MAX_SECS_DEF
) (
    input  logic          clk_1s,
    input  logic          reset,
    time_set_ctrl_if.slave bus
);

    localparam int HW = $clog2(HOLD_SECS + 1);
    localparam int IW = $clog2(TIMEOUT_SECS + 1);
    localparam int RW = $clog2(RING_MAX_SECS + 1);

    localparam logic [HW-1:0] HOLD_TOP  = HW'(HOLD_SECS);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_SECS - 1);
    localparam logic [RW-1:0] RING_TOP  = RW'(RING_MAX_SECS);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_MAX_SECS - 1);

    logic [5:0]    btn_s;
    logic [5:0]    btn_q_r;
    logic [5:0]    press_s;
    logic [HW-1:0] hold_h_r;
    logic [HW-1:0] hold_m_r;
    logic          rep_h_s;
    logic          rep_m_s;
    logic          activity_s;
    logic [IW-1:0] idle_cnt_r;
    logic          timeout_s;
    logic [RW-1:0] ring_cnt_r;
    logic          ring_last_s;

    logic [2:0]    state_r;
    logic [2:0]    next_state_s;
    logic          load_s;
    logic          use_shadow_s;
    logic          edit_hold_s;
    logic          inc_h_s;
    logic          inc_m_s;

    logic [5:0]    hour_val_s;
    logic [7:0]    min_val_s;
    logic [5:0]    hour_ld_s;
    logic [7:0]    min_ld_s;
    logic [5:0]    shadow_h_r;
    logic [7:0]    shadow_m_r;

    logic          ld_time_r;
    logic          ld_alarm_r;
    logic          al_on_r;
    logic          stop_r;
    logic [1:0]    mode_r;

    assign btn_s = {bus.btn_mode, bus.btn_hour, bus.btn_min,
                    bus.btn_set,  bus.btn_al,   bus.btn_stop};

    // A press is a rising level seen at this tick
    assign press_s     = btn_s & ~btn_q_r;
    // Auto-repeat once a button has already been seen high for HOLD_SECS ticks
    assign rep_h_s     = btn_s[B_HOUR] & (hold_h_r == HOLD_TOP);
    assign rep_m_s     = btn_s[B_MIN]  & (hold_m_r == HOLD_TOP);
    assign activity_s  = (|press_s) | rep_h_s | rep_m_s;
    assign timeout_s   = ~activity_s & (idle_cnt_r == IDLE_LAST);
    assign ring_last_s = (ring_cnt_r == RING_LAST);

    // Previous button levels for press detection
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            btn_q_r <= 6'd0;
        end else begin
            btn_q_r <= btn_s;
        end
    end

    // Per-button hold counters, saturating at the repeat threshold
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            hold_h_r <= {HW{1'b0}};
            hold_m_r <= {HW{1'b0}};
        end else begin
            if (!btn_s[B_HOUR]) begin
                hold_h_r <= {HW{1'b0}};
            end else if (hold_h_r != HOLD_TOP) begin
                hold_h_r <= hold_h_r + HW'(1);
            end else begin
                hold_h_r <= hold_h_r;
            end
            if (!btn_s[B_MIN]) begin
                hold_m_r <= {HW{1'b0}};
            end else if (hold_m_r != HOLD_TOP) begin
                hold_m_r <= hold_m_r + HW'(1);
            end else begin
                hold_m_r <= hold_m_r;
            end
        end
    end

    // Next-state logic; set beats mode, and edits only move while staying in an edit state
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        use_shadow_s = 1'b0;
        edit_hold_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (press_s[B_MODE]) begin
                    next_state_s = ST_EDIT_TIME;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EDIT_TIME: begin
                if (press_s[B_SET]) begin
                    next_state_s = ST_COMMIT_T;
                end else if (press_s[B_MODE]) begin
                    next_state_s = ST_EDIT_ALARM;
                    load_s       = 1'b1;
                    use_shadow_s = 1'b1;
                end else if (timeout_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    edit_hold_s  = 1'b1;
                end
            end
            ST_EDIT_ALARM: begin
                if (press_s[B_SET]) begin
                    next_state_s = ST_COMMIT_A;
                end else if (press_s[B_MODE]) begin
                    next_state_s = ST_IDLE;
                end else if (timeout_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    edit_hold_s  = 1'b1;
                end
            end
            ST_COMMIT_T, ST_COMMIT_A: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    assign inc_h_s   = edit_hold_s & (press_s[B_HOUR] | rep_h_s);
    assign inc_m_s   = edit_hold_s & (press_s[B_MIN]  | rep_m_s);
    assign hour_ld_s = use_shadow_s ? shadow_h_r : {bus.cur_h1, bus.cur_h0};
    assign min_ld_s  = use_shadow_s ? shadow_m_r : {bus.cur_m1, bus.cur_m0};

    // FSM state register
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Idle counter: runs only while sitting in an edit state with no activity
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            idle_cnt_r <= {IW{1'b0}};
        end else if (edit_hold_s && !activity_s) begin
            idle_cnt_r <= idle_cnt_r + IW'(1);
        end else begin
            idle_cnt_r <= {IW{1'b0}};
        end
    end

    // Ring counter: consecutive alarm-high ticks, saturating so auto-stop fires once
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            ring_cnt_r <= {RW{1'b0}};
        end else if (!bus.alarm) begin
            ring_cnt_r <= {RW{1'b0}};
        end else if (ring_cnt_r != RING_TOP) begin
            ring_cnt_r <= ring_cnt_r + RW'(1);
        end else begin
            ring_cnt_r <= ring_cnt_r;
        end
    end

    // Alarm shadow: captures the edited value on an alarm commit
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            shadow_h_r <= 6'd0;
            shadow_m_r <= 8'd0;
        end else if (next_state_s == ST_COMMIT_A) begin
            shadow_h_r <= hour_val_s;
            shadow_m_r <= min_val_s;
        end else begin
            shadow_h_r <= shadow_h_r;
            shadow_m_r <= shadow_m_r;
        end
    end

    // Strobes, alarm enable and display mode, all registered
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            ld_time_r  <= 1'b0;
            ld_alarm_r <= 1'b0;
            al_on_r    <= 1'b0;
            stop_r     <= 1'b0;
            mode_r     <= MODE_IDLE;
        end else begin
            ld_time_r  <= (next_state_s == ST_COMMIT_T);
            ld_alarm_r <= (next_state_s == ST_COMMIT_A);
            al_on_r    <= al_on_r ^ press_s[B_AL];
            stop_r     <= bus.alarm & (press_s[B_STOP] | ring_last_s);
            mode_r     <= mode_code(next_state_s);
        end
    end

    bcd_inc #(.TW(2), .MAX(HOUR_MAX)) u_hour (
        .clk      (clk_1s),
        .reset    (reset),
        .load     (load_s),
        .load_val (hour_ld_s),
        .inc      (inc_h_s),
        .value    (hour_val_s)
    );

    bcd_inc #(.TW(4), .MAX(MIN_MAX)) u_min (
        .clk      (clk_1s),
        .reset    (reset),
        .load     (load_s),
        .load_val (min_ld_s),
        .inc      (inc_m_s),
        .value    (min_val_s)
    );

    assign bus.H_in1    = hour_val_s[5:4];
    assign bus.H_in0    = hour_val_s[3:0];
    assign bus.M_in1    = min_val_s[7:4];
    assign bus.M_in0    = min_val_s[3:0];
    assign bus.LD_time  = ld_time_r;
    assign bus.LD_alarm = ld_alarm_r;
    assign bus.AL_ON    = al_on_r;
    assign bus.STOP_al  = stop_r;
    assign bus.mode     = mode_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed scenarios followed by random button/alarm traffic, every tick
// compared against a behavioural model of the time setter kept in plain integers.
module tb_time_set_ctrl;

    localparam int HOLD = 2;
    localparam int TO   = 10;
    localparam int RING = 60;

    // Button vector order: {mode, hour, min, set, al, stop}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] MODE = 6'b100000;
    localparam logic [5:0] HOUR = 6'b010000;
    localparam logic [5:0] MIN  = 6'b001000;
    localparam logic [5:0] SET  = 6'b000100;
    localparam logic [5:0] AL   = 6'b000010;
    localparam logic [5:0] STOP = 6'b000001;

    logic clk_1s = 1'b0;
    logic reset  = 1'b1;

    time_set_ctrl_if bus();

    time_set_ctrl #(
        .HOLD_SECS     (HOLD),
        .TIMEOUT_SECS  (TO),
        .RING_MAX_SECS (RING)
    ) dut (
        .clk_1s (clk_1s),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_1s = ~clk_1s;

    int checks   = 0;
    int failures = 0;

    // Reference model: times as integers, edit kind 0 none / 1 time / 2 alarm
    int         m_h, m_m, m_sh, m_sm;
    int         m_edit, m_commit, m_idle, m_ring, m_hold_h, m_hold_m;
    logic [5:0] m_prev;
    logic       m_al_on, m_ld_t, m_ld_a, m_stop;
    int         cur_h, cur_m;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_m = 0; m_sh = 0; m_sm = 0;
        m_edit = 0; m_commit = 0; m_idle = 0; m_ring = 0;
        m_hold_h = 0; m_hold_m = 0; m_prev = 6'd0;
        m_al_on = 1'b0; m_ld_t = 1'b0; m_ld_a = 1'b0; m_stop = 1'b0;
    endtask

    task automatic model_edge(input logic [5:0] b, input logic al);
        logic [5:0] pr;
        logic       h_req, n_req, act;
        pr    = b & ~m_prev;
        h_req = b[4] && (!m_prev[4] || m_hold_h >= HOLD);
        n_req = b[3] && (!m_prev[3] || m_hold_m >= HOLD);
        act   = (pr != 6'd0) || h_req || n_req;
        m_ld_t = 1'b0;
        m_ld_a = 1'b0;
        if (m_commit != 0) begin
            m_commit = 0;
            m_edit   = 0;
        end else if (m_edit == 0) begin
            if (pr[5]) begin
                m_edit = 1; m_h = cur_h; m_m = cur_m; m_idle = 0;
            end
        end else if (pr[2]) begin
            m_commit = m_edit;
            if (m_edit == 1) m_ld_t = 1'b1;
            else begin
                m_ld_a = 1'b1; m_sh = m_h; m_sm = m_m;
            end
        end else if (pr[5]) begin
            if (m_edit == 1) begin
                m_edit = 2; m_h = m_sh; m_m = m_sm; m_idle = 0;
            end else m_edit = 0;
        end else begin
            if (h_req) m_h = (m_h + 1) % 24;
            if (n_req) m_m = (m_m + 1) % 60;
            if (act) m_idle = 0;
            else m_idle++;
            if (m_idle >= TO) m_edit = 0;
        end
        m_hold_h = b[4] ? ((m_hold_h < 1000) ? m_hold_h + 1 : m_hold_h) : 0;
        m_hold_m = b[3] ? ((m_hold_m < 1000) ? m_hold_m + 1 : m_hold_m) : 0;
        m_stop   = al && (pr[0] || m_ring == RING - 1);
        m_ring   = al ? ((m_ring < 1000) ? m_ring + 1 : m_ring) : 0;
        m_al_on  = m_al_on ^ pr[1];
        m_prev   = b;
    endtask

    task automatic check_all();
        int em;
        em = (m_commit != 0) ? m_commit : m_edit;
        chk("mode",     8'(bus.mode),     8'(em));
        chk("h_in1",    8'(bus.H_in1),    8'(m_h / 10));
        chk("h_in0",    8'(bus.H_in0),    8'(m_h % 10));
        chk("m_in1",    8'(bus.M_in1),    8'(m_m / 10));
        chk("m_in0",    8'(bus.M_in0),    8'(m_m % 10));
        chk("ld_time",  8'(bus.LD_time),  8'(m_ld_t));
        chk("ld_alarm", 8'(bus.LD_alarm), 8'(m_ld_a));
        chk("al_on",    8'(bus.AL_ON),    8'(m_al_on));
        chk("stop_al",  8'(bus.STOP_al),  8'(m_stop));
    endtask

    task automatic drive(input logic [5:0] b, input logic al);
        bus.btn_mode = b[5]; bus.btn_hour = b[4]; bus.btn_min  = b[3];
        bus.btn_set  = b[2]; bus.btn_al   = b[1]; bus.btn_stop = b[0];
        bus.alarm    = al;
        bus.cur_h1   = 2'(cur_h / 10);
        bus.cur_h0   = 4'(cur_h % 10);
        bus.cur_m1   = 4'(cur_m / 10);
        bus.cur_m0   = 4'(cur_m % 10);
    endtask

    // One tick: apply inputs, let the edge happen, advance the model, compare
    task automatic step(input logic [5:0] b, input logic al);
        drive(b, al);
        @(posedge clk_1s);
        model_edge(b, al);
        #1;
        check_all();
    endtask

    initial begin
        logic [5:0] rb;
        logic       ralarm;

        cur_h = 0;
        cur_m = 0;
        drive(NONE, 1'b0);
        model_reset();
        #2;
        check_all();
        #10 reset = 1'b0;

        // Preload from the clock's current time
        cur_h = 12; cur_m = 34;
        step(MODE, 1'b0);
        chk("t1_mode", 8'(bus.mode), 8'd1);
        chk("t1_h", {2'd0, bus.H_in1, bus.H_in0}, 8'h12);
        chk("t1_m", {bus.M_in1, bus.M_in0}, 8'h34);
        step(NONE, 1'b0);
        step(MODE, 1'b0);
        step(NONE, 1'b0);
        step(MODE, 1'b0);
        step(NONE, 1'b0);

        // Wrap 23:59 -> 00:00 with simultaneous hour+min, then commit
        cur_h = 23; cur_m = 59;
        step(MODE, 1'b0);
        step(NONE, 1'b0);
        step(HOUR | MIN, 1'b0);
        chk("t2_hm", {bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0} == 14'd0 ? 8'd1 : 8'd0, 8'd1);
        step(NONE, 1'b0);
        step(SET, 1'b0);
        chk("t2_ld_time", 8'(bus.LD_time), 8'd1);
        step(NONE, 1'b0);
        chk("t2_ld_drop", 8'(bus.LD_time), 8'd0);

        // Alarm edit with auto-repeat, commit, then preload from the shadow
        step(MODE, 1'b0);
        step(NONE, 1'b0);
        step(MODE, 1'b0);
        for (int i = 0; i < 5; i++) step(MIN, 1'b0);
        chk("t3_m_in0", 8'(bus.M_in0), 8'd4);
        step(NONE, 1'b0);
        step(SET, 1'b0);
        chk("t3_ld_alarm", 8'(bus.LD_alarm), 8'd1);
        step(NONE, 1'b0);
        step(MODE, 1'b0);
        step(NONE, 1'b0);
        step(MODE, 1'b0);
        chk("t3_shadow", {bus.M_in1, bus.M_in0}, 8'h04);
        step(NONE, 1'b0);
        step(MODE, 1'b0);
        step(NONE, 1'b0);

        // Timeout out of EDIT_TIME without a load
        cur_h = 7; cur_m = 15;
        step(MODE, 1'b0);
        for (int i = 1; i <= TO; i++) begin
            step(NONE, 1'b0);
            if (i == TO - 1) chk("t4_still_edit", 8'(bus.mode), 8'd1);
        end
        chk("t4_idle", 8'(bus.mode), 8'd0);
        chk("t4_hold", 8'(bus.H_in0), 8'd7);

        // Manual stop, auto stop after RING ticks, no stop while silent
        step(STOP, 1'b1);
        chk("t5_stop", 8'(bus.STOP_al), 8'd1);
        step(NONE, 1'b1);
        step(NONE, 1'b0);
        for (int i = 1; i <= RING; i++) begin
            step(NONE, 1'b1);
            if (i == RING - 1) chk("t5_no_auto_yet", 8'(bus.STOP_al), 8'd0);
        end
        chk("t5_auto", 8'(bus.STOP_al), 8'd1);
        step(NONE, 1'b1);
        step(NONE, 1'b0);
        step(STOP, 1'b0);
        chk("t5_silent", 8'(bus.STOP_al), 8'd0);
        step(NONE, 1'b0);

        // Reset in the middle of a time commit
        cur_h = 10; cur_m = 20;
        step(MODE, 1'b0);
        step(NONE, 1'b0);
        step(SET, 1'b0);
        chk("t6_ld_time", 8'(bus.LD_time), 8'd1);
        drive(NONE, 1'b0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("t6_ld_reset", 8'(bus.LD_time), 8'd0);
        chk("t6_mode_reset", 8'(bus.mode), 8'd0);
        check_all();
        #2 reset = 1'b0;
        step(AL, 1'b0);
        chk("t6_al_on", 8'(bus.AL_ON), 8'd1);
        step(NONE, 1'b0);
        step(AL, 1'b0);
        chk("t6_al_off", 8'(bus.AL_ON), 8'd0);

        // Random traffic against the model
        ralarm = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rb[5] = ($urandom_range(0, 99) < 12);
            rb[4] = ($urandom_range(0, 99) < 35);
            rb[3] = ($urandom_range(0, 99) < 35);
            rb[2] = ($urandom_range(0, 99) < 10);
            rb[1] = ($urandom_range(0, 99) < 8);
            rb[0] = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 99) < 10) ralarm = ~ralarm;
            cur_h = int'($urandom_range(0, 23));
            cur_m = int'($urandom_range(0, 59));
            step(rb, ralarm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
